regfile_writeback: RTL and testbench

- Write-side initiator for the 32x32 register file; it owns the `reg_write` / `write_reg` / `write_data` port.
- Buffers completed results from the execute/load stages in a small in-order FIFO.
- Retires at most one result per cycle into the register file.
- Gives the decode stage a bypass lookup of pending (not yet committed) values for two read addresses.

---
 rtl/regfile_writeback.sv | 88 ++++++++
 tb/tb_regfile_writeback.sv | 126 ++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order result buffer that retires one write per cycle into the 32x32 register file
// Optional feature: define WB_BYPASS_EN to compile the pending-value bypass search.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     result handshake; in_rd/in_data carry destination and value
//   wb_stall              holds retirement while high
//   reg_write/write_reg/write_data  register-file write port (output stage)
//   read_reg1/2 -> byp_hit1/2, byp_data1/2  bypass lookup of pending writes
//   count, empty          FIFO occupancy and overall idle indication
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_rd,
  input  logic [31:0]   in_data,
  input  logic          wb_stall,
  output logic          reg_write,
  output logic [4:0]    write_reg,
  output logic [31:0]   write_data,
  input  logic [4:0]    read_reg1,
  input  logic [4:0]    read_reg2,
  output logic          byp_hit1,
  output logic          byp_hit2,
  output logic [31:0]   byp_data1,
  output logic [31:0]   byp_data2,
  output logic [AW:0]   count,
  output logic          empty
);
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  assign in_ready = count < (AW+1)'(DEPTH);
  // writes to x0 complete the handshake but are never buffered
  assign push = in_valid && in_ready && in_rd != 5'd0;
  assign pop = !wb_stall && count != '0;
  assign empty = count == '0 && !reg_write;
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr] <= in_rd;
      data_q[wr_ptr] <= in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      reg_write <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
    end else begin
      reg_write <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        write_reg <= rd_q[rd_ptr];
        write_data <= data_q[rd_ptr];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef WB_BYPASS_EN
  // oldest candidate first (output stage, then FIFO from head), so the last match is the youngest
  function automatic logic [32:0] lookup(input logic [4:0] a);
    logic [32:0] r;
    r = (reg_write && write_reg == a) ? {1'b1, write_data} : 33'd0;
    for (int k = 0; k < DEPTH; k++)
      if ((AW+1)'(k) < count && rd_q[rd_ptr + AW'(k)] == a) r = {1'b1, data_q[rd_ptr + AW'(k)]};
    return a == 5'd0 ? 33'd0 : r;
  endfunction
  always_comb begin
    {byp_hit1, byp_data1} = lookup(read_reg1);
    {byp_hit2, byp_data2} = lookup(read_reg2);
  end
`else
  logic unused_read_regs;
  assign unused_read_regs = ^{read_reg1, read_reg2};
  assign byp_hit1 = 1'b0;
  assign byp_hit2 = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vector table plus hand sequences for regfile_writeback
module tb_regfile_writeback;
  logic clk = 1'b0, rst_n, in_valid, in_ready, wb_stall, reg_write, byp_hit1, byp_hit2, empty;
  logic [4:0] in_rd, write_reg, read_reg1, read_reg2;
  logic [31:0] in_data, write_data, byp_data1, byp_data2;
  logic [2:0] count;
  int checks = 0, failures = 0;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic rst_n, vld; logic [4:0] rd; logic [31:0] d; logic st; logic [4:0] r1, r2;
    logic rw; logic [4:0] wr; logic [31:0] wd; logic [2:0] cnt; logic rdy, emp, h1; logic [31:0] d1; logic h2;
  } vec_t;
  vec_t vq[$];
  regfile_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_data(in_data), .wb_stall(wb_stall), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2), .byp_hit1(byp_hit1),
    .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2), .count(count), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d want=%0d", nm, i, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic s, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    rst_n = r; in_valid = v; in_rd = rd; in_data = d; wb_stall = s; read_reg1 = a1; read_reg2 = a2;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic r, v, input logic [4:0] rd, input logic [31:0] d, input logic s,
                     input logic [4:0] a1, a2, input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [2:0] cnt, input logic rdy, emp, h1, input logic [31:0] d1, input logic h2);
    vq.push_back('{r, v, rd, d, s, a1, a2, rw, wr, wd, cnt, rdy, emp, h1, d1, h2});
  endtask
  initial begin
    int got;
    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; wb_stall = 1'b0; read_reg1 = '0; read_reg2 = '0;
    add(0,0,0,0,0,0,0,    0,0,0,0,1,1,0,0,0);
    add(0,0,0,0,0,0,0,    0,0,0,0,1,1,0,0,0);
    add(1,1,20,1024,0,0,0, 0,0,0,1,1,0,0,0,0);
    add(1,0,0,0,0,0,0,    1,20,1024,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,    0,20,1024,0,1,1,0,0,0);
    add(1,1,2,2048,0,0,0, 0,20,1024,1,1,0,0,0,0);
    add(1,1,3,2049,0,0,0, 1,2,2048,1,1,0,0,0,0);
    add(1,1,4,2050,0,0,0, 1,3,2049,1,1,0,0,0,0);
    add(1,1,5,2051,0,0,0, 1,4,2050,1,1,0,0,0,0);
    add(1,1,6,2052,0,0,0, 1,5,2051,1,1,0,0,0,0);
    add(1,0,0,0,0,0,0,    1,6,2052,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,    0,6,2052,0,1,1,0,0,0);
    add(1,1,7,100,1,0,0,  0,6,2052,1,1,0,0,0,0);
    add(1,1,8,101,1,0,0,  0,6,2052,2,1,0,0,0,0);
    add(1,1,9,102,1,0,0,  0,6,2052,3,1,0,0,0,0);
    add(1,1,10,103,1,0,0, 0,6,2052,4,0,0,0,0,0);
    add(1,1,11,104,1,0,0, 0,6,2052,4,0,0,0,0,0);
    add(1,1,11,104,0,0,0, 1,7,100,3,1,0,0,0,0);
    add(1,1,11,104,0,0,0, 1,8,101,3,1,0,0,0,0);
    add(1,0,0,0,0,0,0,    1,9,102,2,1,0,0,0,0);
    add(1,0,0,0,0,0,0,    1,10,103,1,1,0,0,0,0);
    add(1,0,0,0,0,0,0,    1,11,104,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,    0,11,104,0,1,1,0,0,0);
    add(1,1,0,4096,0,0,0, 0,11,104,0,1,1,0,0,0);
    add(1,0,0,0,0,0,0,    0,11,104,0,1,1,0,0,0);
    add(1,1,30,4096,1,30,15, 0,11,104,1,1,0,1,4096,0);
    add(1,1,30,8192,1,30,15, 0,11,104,2,1,0,1,8192,0);
    add(1,0,0,0,0,30,15,  1,30,4096,1,1,0,1,8192,0);
    add(1,0,0,0,0,30,15,  1,30,8192,0,1,0,1,8192,0);
    add(1,0,0,0,0,30,15,  0,30,8192,0,1,1,0,0,0);
    add(1,1,12,200,1,0,0, 0,30,8192,1,1,0,0,0,0);
    add(1,1,13,201,1,0,0, 0,30,8192,2,1,0,0,0,0);
    add(1,1,14,202,1,0,0, 0,30,8192,3,1,0,0,0,0);
    add(0,0,0,0,0,0,0,    0,0,0,0,1,1,0,0,0);
    add(1,0,0,0,0,0,0,    0,0,0,0,1,1,0,0,0);
    add(1,0,0,0,0,0,0,    0,0,0,0,1,1,0,0,0);
    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].vld, vq[i].rd, vq[i].d, vq[i].st, vq[i].r1, vq[i].r2);
      chk("reg_write", i, 32'(reg_write), 32'(vq[i].rw));
      chk("write_reg", i, 32'(write_reg), 32'(vq[i].wr));
      chk("write_data", i, write_data, vq[i].wd);
      chk("count", i, 32'(count), 32'(vq[i].cnt));
      chk("in_ready", i, 32'(in_ready), 32'(vq[i].rdy));
      chk("empty", i, 32'(empty), 32'(vq[i].emp));
      chk("byp_hit1", i, 32'(byp_hit1), 32'(vq[i].h1 & BYP));
      chk("byp_hit2", i, 32'(byp_hit2), 32'(vq[i].h2 & BYP));
      if (!BYP || vq[i].h1) chk("byp_data1", i, byp_data1, BYP ? vq[i].d1 : 32'd0);
    end
    // stalled fill of four writes to one register, then in-order drain with a bounded wait
    for (int k = 0; k < 4; k++) drive(1, 1, 9, 300 + k, 1, 9, 0);
    chk("fill_count", 0, 32'(count), 4);
    chk("fill_ready", 0, 32'(in_ready), 0);
    chk("fill_byp", 0, 32'(byp_hit1), 32'(BYP));
    if (BYP) chk("fill_byp_data", 0, byp_data1, 303);
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      if (reg_write) begin
        chk("drain_reg", got, 32'(write_reg), 9);
        chk("drain_data", got, write_data, 300 + got);
        got++;
      end
    end
    chk("drain_total", 0, got, 4);
    // sustained stream of eight: one pulse per cycle, occupancy never above one
    for (int k = 0; k < 9; k++) begin
      drive(1, k < 8, 5'(k + 1), 500 + k, 0, 0, 0);
      chk("stream_count", k, 32'(count <= 1), 1);
      chk("stream_ready", k, 32'(in_ready), 1);
      if (k > 0) begin
        chk("stream_rw", k, 32'(reg_write), 1);
        chk("stream_data", k, write_data, 500 + k - 1);
      end
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("stream_idle", 0, 32'(empty), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
